mmu_wr_sched: RTL

//  Shares one credit-gated write-request path among N_REGIONS vFPGA requesters.
//  - Round-robin arbitration; a request is granted only if its region has buffered enough write-data beats.
//  - Keeps per-region beat-credit counters, issues one request stream downstream, and queues grant order.
//  - The queued order steers write data. Sits between the per-region write queues and the shared TLB/DMA write port.

---
 rtl/mmu_wr_sched.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mmu_wr_sched.sv
// -----------------------------------------------------------------------------
// mmu_wr_sched
//   Credit-gated round-robin scheduler. Several vFPGA regions share one write
//   request port. A region can win the port only if it has already buffered
//   every write-data beat its request needs. Granted requests go out through a
//   single registered request channel. Their order is recorded in a small FIFO,
//   and the FIFO head tells the data path which region's beats to forward next.
//
// Ports
//   aclk, areset            clock, synchronous active-high reset
//   s_req_valid/len/ready   per-region request; ready is one-hot or zero and
//                           is driven combinationally in the grant cycle
//   wxfer                   one write-data beat buffered for region i (credit +1)
//   m_req_valid/len/id      registered downstream request, held until m_req_ready
//   m_req_ready             downstream accept
//   m_sel_valid/id/last     data steering from the grant-order FIFO head
//   dxfer                   one data beat forwarded for m_sel_id
// -----------------------------------------------------------------------------
module mmu_wr_sched #(
    parameter int N_REGIONS = 4,
    parameter int LEN_BITS  = 28,
    parameter int DATA_BITS = 512,
    parameter int SEQ_DEPTH = 8
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [N_REGIONS-1:0]           s_req_valid,
    input  logic [N_REGIONS*LEN_BITS-1:0]  s_req_len,
    output logic [N_REGIONS-1:0]           s_req_ready,
    input  logic [N_REGIONS-1:0]           wxfer,
    output logic                           m_req_valid,
    output logic [LEN_BITS-1:0]            m_req_len,
    output logic [$clog2(N_REGIONS)-1:0]   m_req_id,
    input  logic                           m_req_ready,
    output logic                           m_sel_valid,
    output logic [$clog2(N_REGIONS)-1:0]   m_sel_id,
    output logic                           m_sel_last,
    input  logic                           dxfer
);

    localparam int BEAT_BYTES = DATA_BITS / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int NB_W       = LEN_BITS - BEAT_SHIFT + 1;
    localparam int ID_W       = $clog2(N_REGIONS);
    localparam int PTR_W      = $clog2(SEQ_DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // ---------------------------------------------------------------- state
    logic [0:0]          state_q,    state_d;
    logic [LEN_BITS-1:0] req_len_q,  req_len_d;
    logic [ID_W-1:0]     req_id_q,   req_id_d;
    logic [ID_W-1:0]     rr_ptr_q,   rr_ptr_d;
    logic [NB_W-1:0]     cnt_q [N_REGIONS];
    logic [NB_W-1:0]     cnt_d [N_REGIONS];
    logic [PTR_W:0]      wr_ptr_q,   wr_ptr_d;
    logic [PTR_W:0]      rd_ptr_q,   rd_ptr_d;
    logic [NB_W-1:0]     head_cnt_q, head_cnt_d;
    logic [ID_W-1:0]     fifo_id_q [SEQ_DEPTH];
    logic [NB_W-1:0]     fifo_nb_q [SEQ_DEPTH];

    // ---------------------------------------------------------------- decode
    logic [LEN_BITS-1:0]  len_a [N_REGIONS];
    logic [NB_W-1:0]      nb    [N_REGIONS];
    logic [N_REGIONS-1:0] eligible;

    // Beats needed = ceil(len / BEAT_BYTES): whole beats plus one for any tail.
    always_comb begin
        for (int i = 0; i < N_REGIONS; i++) begin
            len_a[i]    = s_req_len[i*LEN_BITS +: LEN_BITS];
            nb[i]       = NB_W'(len_a[i] >> BEAT_SHIFT) + NB_W'(|len_a[i][BEAT_SHIFT-1:0]);
            // Registered credits only: a beat arriving this cycle cannot fund this cycle's grant.
            eligible[i] = s_req_valid[i] && (cnt_q[i] >= nb[i]);
        end
    end

    // ---------------------------------------------------------------- FIFO status
    logic            fifo_empty, fifo_full, pop;
    logic [NB_W-1:0] head_nb;

    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                         (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_nb     = fifo_nb_q[rd_ptr_q[PTR_W-1:0]];
    assign m_sel_valid = !fifo_empty;
    assign m_sel_id    = fifo_id_q[rd_ptr_q[PTR_W-1:0]];
    assign m_sel_last  = !fifo_empty && (head_cnt_q == head_nb - NB_W'(1));
    assign pop         = dxfer && m_sel_last;

    // ---------------------------------------------------------------- arbiter
    logic            can_issue, any_elig, grant_fire, grant_push;
    logic [ID_W-1:0] grant_id;
    logic [ID_W:0]   rr_sum;
    logic [NB_W-1:0] grant_nb;

    // A pop in the same cycle frees the slot a full FIFO needs, so issue can resume at once.
    assign can_issue = ((state_q == ST_IDLE) || m_req_ready) && (!fifo_full || pop);

    // Scan starting at rr_ptr and wrapping; the first eligible region wins.
    always_comb begin
        any_elig = 1'b0;
        grant_id = '0;
        rr_sum   = '0;
        for (int k = 0; k < N_REGIONS; k++) begin
            rr_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (rr_sum >= (ID_W+1)'(N_REGIONS)) begin
                rr_sum = rr_sum - (ID_W+1)'(N_REGIONS);
            end
            if (!any_elig && eligible[rr_sum[ID_W-1:0]]) begin
                any_elig = 1'b1;
                grant_id = rr_sum[ID_W-1:0];
            end
        end
    end

    assign grant_fire  = any_elig && can_issue && !areset;
    assign grant_nb    = nb[grant_id];
    // Zero-length requests are acknowledged but never issued or queued.
    assign grant_push  = grant_fire && (grant_nb != '0);
    assign s_req_ready = grant_fire ? (N_REGIONS'(1) << grant_id) : '0;

    assign m_req_valid = (state_q == ST_HOLD);
    assign m_req_len   = req_len_q;
    assign m_req_id    = req_id_q;

    // ---------------------------------------------------------------- next state
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        req_len_d  = req_len_q;
        req_id_d   = req_id_q;
        rr_ptr_d   = rr_ptr_q;
        wr_ptr_d   = wr_ptr_q + (PTR_W+1)'(grant_push);
        rd_ptr_d   = rd_ptr_q + (PTR_W+1)'(pop);
        head_cnt_d = head_cnt_q;

        if ((state_q == ST_HOLD) && m_req_ready) begin
            state_d = ST_IDLE;
        end
        if (grant_push) begin
            state_d   = ST_HOLD;
            req_len_d = len_a[grant_id];
            req_id_d  = grant_id;
        end
        if (grant_fire) begin
            rr_ptr_d = (grant_id == ID_W'(N_REGIONS - 1)) ? '0 : grant_id + ID_W'(1);
        end

        if (pop) begin
            head_cnt_d = '0;
        end else if (dxfer && !fifo_empty) begin
            head_cnt_d = head_cnt_q + NB_W'(1);
        end

        // Beat arrival and grant debit both land in the same cycle; arrivals stop at all-ones.
        for (int i = 0; i < N_REGIONS; i++) begin
            cnt_d[i] = cnt_q[i]
                     + NB_W'(wxfer[i] && (cnt_q[i] != '1))
                     - ((grant_fire && (grant_id == ID_W'(i))) ? nb[i] : '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= ST_IDLE;
            req_len_q  <= '0;
            req_id_q   <= '0;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            head_cnt_q <= '0;
            for (int i = 0; i < N_REGIONS; i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            req_len_q  <= req_len_d;
            req_id_q   <= req_id_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            head_cnt_q <= head_cnt_d;
            for (int i = 0; i < N_REGIONS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // NOTE: FIFO storage is left unreset; the pointers alone define which entries are valid.
    always_ff @(posedge aclk) begin
        if (grant_push) begin
            fifo_id_q[wr_ptr_q[PTR_W-1:0]] <= grant_id;
            fifo_nb_q[wr_ptr_q[PTR_W-1:0]] <= grant_nb;
        end
    end

endmodule
